// File: rtl/bus_share_arbiter_pkg.sv
// Shared definitions for the two-requester bus share arbiter:
// FSM state encoding, source tags and datapath width.
package bus_share_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/mux_32bit.sv
// 32-bit 2:1 mux: o = a when s=1, b when s=0.
module mux_32bit
    import bus_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              s,
    output logic [DATA_W-1:0] o
);

    // Pure select, no state.
    assign o = s ? a : b;

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin burst arbiter sharing one 32-bit datapath between requesters
// A and B, with a single-entry valid/ready output register.
//
// state | meaning
// IDLE  | nobody owns the datapath; arbitrate (never acks here)
// OWN_A | A owns the mux (s=1); A words accepted while the slot is free
// OWN_B | B owns the mux (s=0); B words accepted while the slot is free
module bus_share_arbiter
    import bus_share_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter bit A_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ack,
    output logic              s,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_src,
    input  logic              o_ready
);

    // One spare bit so the counter cannot wrap before the release compare fires.
    localparam int               CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t             state;
    logic               prio;
    logic [CNT_W-1:0]   cnt;
    logic               slot_free;
    logic               burst_end;
    logic               a_release;
    logic               b_release;
    logic [DATA_W-1:0]  mux_o;

    mux_32bit u_mux (
        .a (a_data),
        .b (b_data),
        .s (s),
        .o (mux_o)
    );

    // Select and acks decode straight from the registered state.
    assign s         = (state == OWN_A);
    assign slot_free = !o_valid || o_ready;
    assign a_ack     = (state == OWN_A) && a_req && slot_free;
    assign b_ack     = (state == OWN_B) && b_req && slot_free;
    assign burst_end = (cnt == CNT_LAST);

    // A stalled owner (req high, slot busy) keeps ownership and its count.
    assign a_release = !a_req || (a_ack && (a_last || burst_end));
    assign b_release = !b_req || (b_ack && (b_last || burst_end));

    // Ownership FSM, round-robin priority and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= A_FIRST;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (a_req && (!b_req || prio)) begin
                        state <= OWN_A;
                    end else if (b_req) begin
                        state <= OWN_B;
                    end
                end
                OWN_A: begin
                    if (a_release) begin
                        prio  <= 1'b0;
                        cnt   <= '0;
                        state <= b_req ? OWN_B : IDLE;
                    end else if (a_ack) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OWN_B: begin
                    if (b_release) begin
                        prio  <= 1'b1;
                        cnt   <= '0;
                        state <= a_req ? OWN_A : IDLE;
                    end else if (b_ack) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output stage: load on accept (replacing a word being drained), clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= SRC_B;
        end else if (a_ack || b_ack) begin
            o_valid <= 1'b1;
            o_data  <= mux_o;
            o_src   <= s ? SRC_A : SRC_B;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: vector table plus hand-written sequences,
// with a scoreboard queue of expected output words.
module tb_bus_share_arbiter;
    import bus_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_last, b_req, b_last, o_ready;
    logic [31:0] a_data, b_data;

    logic        a_ack, b_ack, s, o_valid, o_src;
    logic [31:0] o_data;
    logic        a_ack1, b_ack1, s1, o_valid1, o_src1;
    logic [31:0] o_data1;

    always #5 clk = ~clk;

    bus_share_arbiter #(.MAX_BURST(4), .A_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_last(a_last), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_last(b_last), .b_ack(b_ack),
        .s(s), .o_valid(o_valid), .o_data(o_data), .o_src(o_src), .o_ready(o_ready)
    );

    bus_share_arbiter #(.MAX_BURST(1), .A_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_last(a_last), .a_ack(a_ack1),
        .b_req(b_req), .b_data(b_data), .b_last(b_last), .b_ack(b_ack1),
        .s(s1), .o_valid(o_valid1), .o_data(o_data1), .o_src(o_src1), .o_ready(o_ready)
    );

    typedef struct packed {
        logic        a_req;
        logic [31:0] a_data;
        logic        a_last;
        logic        b_req;
        logic [31:0] b_data;
        logic        b_last;
        logic        o_ready;
        logic        ea;
        logic        eb;
        logic        es;
    } vec_t;

    typedef struct packed {
        logic        src;
        logic [31:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t mq[$];
    exp_t e;
    logic exp_valid;
    logic ev1, ea1, eb1;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic ar, input logic [31:0] ad, input logic al,
                                input logic br, input logic [31:0] bd, input logic bl,
                                input logic rdy, input logic ea, input logic eb, input logic es);
        vec_t v;
        v.a_req = ar; v.a_data = ad; v.a_last = al;
        v.b_req = br; v.b_data = bd; v.b_last = bl;
        v.o_ready = rdy; v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the MAX_BURST=4 instance: drive, check mid-cycle, then clock.
    task automatic apply(input vec_t v);
        a_req = v.a_req; a_data = v.a_data; a_last = v.a_last;
        b_req = v.b_req; b_data = v.b_data; b_last = v.b_last;
        o_ready = v.o_ready;
        #2;
        chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
        if (exp_valid && v.o_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got drain expected queued word at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_src", {31'd0, o_src}, {31'd0, e.src});
            end
        end
        chk("a_ack", {31'd0, a_ack}, {31'd0, v.ea});
        chk("b_ack", {31'd0, b_ack}, {31'd0, v.eb});
        chk("s", {31'd0, s}, {31'd0, v.es});
        if (v.ea) sb.push_back({SRC_A, v.a_data});
        if (v.eb) sb.push_back({SRC_B, v.b_data});
        if (v.ea || v.eb) exp_valid = 1'b1;
        else if (v.o_ready) exp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Contention from reset: A x4, B x4, A again; then both drop.
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(1'b1, 32'hA000_0000 + i, 1'b0, 1'b1, 32'hB000_0000 + i, 1'b0, 1'b1,
                             (i >= 1 && i <= 4) || i == 9, (i >= 5 && i <= 8),
                             (i >= 1 && i <= 4) || i == 9));
        end
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        // Requester drop: prio=B enters OWN_B, B drops after 2 words, then A wins a tie.
        tbl.push_back(mk(1'b1, 32'h0000_00A1, 1'b0, 1'b1, 32'h0000_00C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00C1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00C2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0000_00A5, 1'b0, 1'b1, 32'h0000_00C5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0000_00A6, 1'b0, 1'b1, 32'h0000_00C6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        // Early last: A's second word ends its burst, B takes over with no bubble.
        tbl.push_back(mk(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hB0B0_B0B0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'hB0B0_B0B0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'hB0B0_B0B0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Reset state, with both requests high so the acks are meaningful.
        rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_last = 1'b0; b_last = 1'b0;
        a_data = 32'h5555_5555; b_data = 32'hAAAA_AAAA; o_ready = 1'b0;
        #12;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_src", {31'd0, o_src}, 32'd0);
        chk("rst_s", {31'd0, s}, 32'd0);
        chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_valid = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Back-pressure: stall 3 cycles in OWN_A with DEADBEEF held; count must not move.
        apply(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            apply(mk(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            chk("stall_hold", o_data, 32'hDEAD_BEEF);
        end
        apply(mk(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b1, 32'h1234_5679, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b1, 32'h1234_567A, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Reset mid-burst: async clear while OWN_A holds a word, then one IDLE cycle.
        apply(mk(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        chk("pre_rst_valid", {31'd0, o_valid}, {31'd0, exp_valid});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_o_valid", {31'd0, o_valid}, 32'd0);
        chk("async_o_data", o_data, 32'd0);
        chk("async_o_src", {31'd0, o_src}, 32'd0);
        chk("async_s", {31'd0, s}, 32'd0);
        chk("async_a_ack", {31'd0, a_ack}, 32'd0);
        sb.delete();
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(1'b1, 32'hCAFE_0002, 1'b0, 1'b1, 32'hBEEF_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 32'hCAFE_0003, 1'b0, 1'b1, 32'hBEEF_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // MAX_BURST=1 instance: strict A,B alternation under contention.
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a_req = 1'b1; b_req = 1'b1; a_last = 1'b0; b_last = 1'b0; o_ready = 1'b1;
            a_data = 32'hAAAA_0000 + k;
            b_data = 32'hBBBB_0000 + k;
            #2;
            ea1 = (k % 2 == 1);
            eb1 = (k >= 2) && (k % 2 == 0);
            chk("mb1_o_valid", {31'd0, o_valid1}, {31'd0, ev1});
            if (ev1) begin
                if (mq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mb1_empty: got drain expected queued word at %0t", $time);
                end else begin
                    e = mq.pop_front();
                    chk("mb1_o_data", o_data1, e.data);
                    chk("mb1_o_src", {31'd0, o_src1}, {31'd0, e.src});
                end
            end
            chk("mb1_a_ack", {31'd0, a_ack1}, {31'd0, ea1});
            chk("mb1_b_ack", {31'd0, b_ack1}, {31'd0, eb1});
            chk("mb1_s", {31'd0, s1}, {31'd0, ea1});
            if (ea1) mq.push_back({SRC_A, a_data});
            if (eb1) mq.push_back({SRC_B, b_data});
            ev1 = ea1 || eb1;
            @(posedge clk);
            #1;
        end
        a_req = 1'b0; b_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
